timer_controller: RTL and testbench

Sequencing controller for the microwave countdown timer. Collects mm:ss digits from the keypad decoder, loads them into the mod-10/mod-6 down-counter chain, gates the chain's count enable with the 1 Hz strobe while cooking, and handles pause, door-open, clear and end-of-cook alarm. Sits between keypad/button conditioning and the counter chain; drives the magnetron enable and alarm outputs.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/bcd_entry_reg.sv | 27 ++
 rtl/timer_controller.sv | 130 +++++++++++++
 tb/tb_timer_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants and helpers for the microwave timer controller.
// State encoding, BCD digit width and digit validation.
package timer_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ENTRY = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_COOK  = 3'd4;
  localparam logic [2:0] S_PAUSE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  function automatic logic digit_ok(
    input logic [DIGIT_W-1:0] d
  );
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Four-digit BCD keypad entry register.
// New digits shift in at the right; non-BCD digits are ignored.
module bcd_entry_reg
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               first,
  input  logic               shift,
  input  logic [DIGIT_W-1:0] digit,
  output logic [15:0]        q
);

  // clear wins; first digit restarts the entry, later ones shift left
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 16'h0000;
    end else if (digit_ok(digit)) begin
      if (first) begin
        q <= {12'h000, digit};
      end else if (shift) begin
        q <= {q[11:0], digit};
      end
    end
  end

endmodule

// File: rtl/timer_controller.sv
// Microwave countdown sequencing controller.
// Keypad entry, counter load/enable, pause, door and alarm handling.
module timer_controller
  import timer_pkg::*;
#(
  parameter int ALARM_TICKS = 3
) (
  input  logic               clk,
  input  logic               clearn,
  input  logic               tick_1hz,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               start,
  input  logic               stop_clear,
  input  logic               door_closed,
  input  logic               zero_all,
  output logic [15:0]        load_data,
  output logic               cnt_loadn,
  output logic               cnt_en,
  output logic               cnt_clearn,
  output logic               mag_on,
  output logic               done,
  output logic [2:0]         state
);

  localparam int AW = $clog2(ALARM_TICKS + 1);

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [AW-1:0] alarm_q;
  logic [15:0]   entry;
  logic          key_ok;
  logic          start_ok;
  logic          alarm_end;
  logic          ent_clr;
  logic          ent_first;
  logic          ent_shift;

  assign key_ok   = key_valid & digit_ok(key_digit);
  assign start_ok = start & door_closed
                  & (entry != 16'h0000)
                  & (entry[7:4] <= MAX_SEC_TENS);
  assign alarm_end = tick_1hz
                   & (alarm_q == AW'(ALARM_TICKS - 1));

  // next-state logic; stop_clear outranks start in IDLE/ENTRY
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CLEAR: state_d = S_IDLE;
      S_IDLE: begin
        if (stop_clear)  state_d = S_CLEAR;
        else if (key_ok) state_d = S_ENTRY;
      end
      S_ENTRY: begin
        if (stop_clear)    state_d = S_CLEAR;
        else if (start_ok) state_d = S_LOAD;
      end
      S_LOAD: state_d = S_COOK;
      S_COOK: begin
        if (zero_all)         state_d = S_DONE;
        else if (stop_clear)  state_d = S_PAUSE;
        else if (!door_closed) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (stop_clear)                state_d = S_CLEAR;
        else if (start & door_closed)  state_d = S_COOK;
      end
      S_DONE: begin
        if (stop_clear | key_ok) state_d = S_IDLE;
        else if (alarm_end)      state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // entry is zeroed on the way into CLEAR so it reads 0 there
  assign ent_clr   = !clearn | (state_d == S_CLEAR);
  assign ent_first = (state_q == S_IDLE)
                   & (state_d == S_ENTRY);
  assign ent_shift = key_valid
                   & (state_q == S_ENTRY)
                   & (state_d == S_ENTRY);

  bcd_entry_reg u_entry (
    .clk   (clk),
    .clr   (ent_clr),
    .first (ent_first),
    .shift (ent_shift),
    .digit (key_digit),
    .q     (entry)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!clearn) state_q <= S_CLEAR;
    else         state_q <= state_d;
  end

  // alarm tick counter, only live in DONE
  always_ff @(posedge clk) begin
    if (!clearn) begin
      alarm_q <= '0;
    end else if (state_q != S_DONE) begin
      alarm_q <= '0;
    end else if (tick_1hz) begin
      alarm_q <= alarm_q + AW'(1);
    end
  end

  // Moore decode plus the single Mealy count enable
  always_comb begin
    cnt_clearn = 1'b1;
    cnt_loadn  = 1'b1;
    mag_on     = 1'b0;
    done       = 1'b0;
    unique case (1'b1)
      (state_q == S_CLEAR): cnt_clearn = 1'b0;
      (state_q == S_LOAD):  cnt_loadn  = 1'b0;
      (state_q == S_COOK):  mag_on     = 1'b1;
      (state_q == S_DONE):  done       = 1'b1;
      default: ;
    endcase
  end

  assign cnt_en    = mag_on & tick_1hz & !zero_all;
  assign load_data = entry;
  assign state     = state_q;

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller.
// Expectations queued at stimulus time, popped when outputs settle.
module tb_timer_controller;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        clearn = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'h0;
  logic        start = 1'b0;
  logic        stop_clear = 1'b0;
  logic        door_closed = 1'b1;
  logic        zero_all;
  logic [15:0] load_data;
  logic        cnt_loadn;
  logic        cnt_en;
  logic        cnt_clearn;
  logic        mag_on;
  logic        done;
  logic [2:0]  state;

  timer_controller #(.ALARM_TICKS(3)) dut (
    .clk         (clk),
    .clearn      (clearn),
    .tick_1hz    (tick_1hz),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop_clear  (stop_clear),
    .door_closed (door_closed),
    .zero_all    (zero_all),
    .load_data   (load_data),
    .cnt_loadn   (cnt_loadn),
    .cnt_en      (cnt_en),
    .cnt_clearn  (cnt_clearn),
    .mag_on      (mag_on),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  // counter-chain stand-in: remaining count, zero flag
  logic [15:0] m = 16'h0000;
  assign zero_all = (m == 16'h0000);

  always @(posedge clk) begin
    if (!cnt_loadn)       m <= load_data;
    else if (!cnt_clearn) m <= 16'h0000;
    else if (cnt_en)      m <= m - 16'd1;
  end

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [15:0] d;
    logic        en;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic cmp(string tag, string what,
                     logic [15:0] got,
                     logic [15:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s.%s got=%h want=%h",
             tag, what, got, want);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      cmp(e.tag, "state", 16'(state), 16'(e.st));
      cmp(e.tag, "load_data", load_data, e.d);
      cmp(e.tag, "cnt_en", 16'(cnt_en), 16'(e.en));
      cmp(e.tag, "cnt_clearn", 16'(cnt_clearn),
          16'(e.st != S_CLEAR));
      cmp(e.tag, "cnt_loadn", 16'(cnt_loadn),
          16'(e.st != S_LOAD));
      cmp(e.tag, "mag_on", 16'(mag_on),
          16'(e.st == S_COOK));
      cmp(e.tag, "done", 16'(done),
          16'(e.st == S_DONE));
    end
  endtask

  task automatic obs(string tag, logic [2:0] st,
                     logic [15:0] d, logic en);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.d   = d;
    e.en  = en;
    q.push_back(e);
    #1;
    drain();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    key_valid  = 1'b0;
    start      = 1'b0;
    stop_clear = 1'b0;
    tick_1hz   = 1'b0;
  endtask

  task automatic key(logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    cyc();
  endtask

  initial begin
    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      cyc();
      obs("rst", S_CLEAR, 16'h0000, 1'b0);
    end
    clearn = 1'b1;
    obs("rel_clear", S_CLEAR, 16'h0000, 1'b0);
    cyc();
    obs("rel_idle", S_IDLE, 16'h0000, 1'b0);
    start = 1'b1;
    cyc();
    obs("idle_start", S_IDLE, 16'h0000, 1'b0);

    // 12:30 cook, then stop twice
    key(4'd1);
    obs("k1", S_ENTRY, 16'h0001, 1'b0);
    key(4'd2);
    key(4'd3);
    key(4'd0);
    obs("k1230", S_ENTRY, 16'h1230, 1'b0);
    key(4'hC);
    obs("bad_digit", S_ENTRY, 16'h1230, 1'b0);
    start = 1'b1;
    cyc();
    obs("load", S_LOAD, 16'h1230, 1'b0);
    cyc();
    obs("cook", S_COOK, 16'h1230, 1'b0);
    tick_1hz = 1'b1;
    obs("cook_tick", S_COOK, 16'h1230, 1'b1);
    cyc();
    stop_clear = 1'b1;
    cyc();
    obs("stop_pause", S_PAUSE, 16'h1230, 1'b0);
    stop_clear = 1'b1;
    cyc();
    obs("pause_clr", S_CLEAR, 16'h0000, 1'b0);
    cyc();
    obs("clr_idle", S_IDLE, 16'h0000, 1'b0);

    // refused starts
    key(4'd0);
    start = 1'b1;
    cyc();
    obs("zero_refused", S_ENTRY, 16'h0000, 1'b0);
    key(4'd9);
    key(4'd9);
    key(4'd7);
    key(4'd5);
    obs("k9975", S_ENTRY, 16'h9975, 1'b0);
    start = 1'b1;
    cyc();
    obs("sec_tens_refused", S_ENTRY, 16'h9975, 1'b0);
    key(4'd5);
    obs("k9755", S_ENTRY, 16'h9755, 1'b0);
    door_closed = 1'b0;
    start = 1'b1;
    cyc();
    obs("door_refused", S_ENTRY, 16'h9755, 1'b0);
    door_closed = 1'b1;
    stop_clear = 1'b1;
    cyc();
    obs("entry_clr", S_CLEAR, 16'h0000, 1'b0);
    cyc();
    obs("entry_idle", S_IDLE, 16'h0000, 1'b0);

    // 00:02 cook to completion and alarm
    key(4'd0);
    key(4'd0);
    key(4'd0);
    key(4'd2);
    start = 1'b1;
    cyc();
    cyc();
    obs("c2_cook", S_COOK, 16'h0002, 1'b0);
    tick_1hz = 1'b1;
    obs("c2_t1", S_COOK, 16'h0002, 1'b1);
    cyc();
    tick_1hz = 1'b1;
    obs("c2_t2", S_COOK, 16'h0002, 1'b1);
    cyc();
    tick_1hz = 1'b1;
    obs("c2_zero", S_COOK, 16'h0002, 1'b0);
    cyc();
    obs("done0", S_DONE, 16'h0002, 1'b0);
    tick_1hz = 1'b1;
    cyc();
    cyc();
    obs("done1", S_DONE, 16'h0002, 1'b0);
    tick_1hz = 1'b1;
    cyc();
    obs("done2", S_DONE, 16'h0002, 1'b0);
    tick_1hz = 1'b1;
    cyc();
    obs("done_idle", S_IDLE, 16'h0002, 1'b0);

    // start + key same cycle, then door pause
    key(4'd3);
    key(4'd0);
    obs("k0030", S_ENTRY, 16'h0030, 1'b0);
    key_valid = 1'b1;
    key_digit = 4'd4;
    start = 1'b1;
    cyc();
    obs("start_wins", S_LOAD, 16'h0030, 1'b0);
    cyc();
    door_closed = 1'b0;
    cyc();
    obs("door_pause", S_PAUSE, 16'h0030, 1'b0);
    tick_1hz = 1'b1;
    obs("pause_tick", S_PAUSE, 16'h0030, 1'b0);
    start = 1'b1;
    cyc();
    obs("open_start", S_PAUSE, 16'h0030, 1'b0);
    door_closed = 1'b1;
    start = 1'b1;
    cyc();
    obs("resume", S_COOK, 16'h0030, 1'b0);
    cmp("resume", "model_cnt", m, 16'h0030);
    stop_clear = 1'b1;
    cyc();
    stop_clear = 1'b1;
    cyc();
    cyc();
    obs("p_idle", S_IDLE, 16'h0000, 1'b0);

    // five keys keep the last four
    for (int i = 1; i <= 5; i++) key(4'(i));
    obs("k2345", S_ENTRY, 16'h2345, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
